// File: rtl/cpu_clk_rst_seq.sv
// CPU clock/reset bring-up sequencer on the free-running board clock.
// Filters PLL lock, opens the CPU clock gate, then releases the CPU reset.
module cpu_clk_rst_seq #(
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int RST_HOLD_CYCLES    = 8,
    parameter int CNT_W              = 8
) (
    input  logic       fpga_clk,
    input  logic       rst_n,
    input  logic       clk_lock,
    input  logic       soft_rst,
    output logic       clk_en,
    output logic       cpu_rst_n,
    output logic       seq_ready,
    output logic [1:0] seq_state,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

    logic             r_sync1;
    logic             r_lock_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_en;
    logic             r_cpu_rst_n;
    logic             r_seq_ready;
    logic [7:0]       r_loss_cnt;

    // clk_lock comes from the PLL domain; two flops before any decision uses it.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= clk_lock;
            r_lock_s <= r_sync1;
        end
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT;
            r_cnt       <= '0;
            r_clk_en    <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_seq_ready <= 1'b0;
            r_loss_cnt  <= 8'd0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (!r_lock_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_state  <= ST_HOLD;
                        r_cnt    <= '0;
                        r_clk_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Losing lock before RUN is not counted as a lock-loss event.
                    if (!r_lock_s) begin
                        r_state  <= ST_WAIT;
                        r_cnt    <= '0;
                        r_clk_en <= 1'b0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_cpu_rst_n <= 1'b1;
                        r_seq_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Lock loss takes priority over a coincident soft reset.
                    if (!r_lock_s) begin
                        r_state     <= ST_WAIT;
                        r_cnt       <= '0;
                        r_clk_en    <= 1'b0;
                        r_cpu_rst_n <= 1'b0;
                        r_seq_ready <= 1'b0;
                        if (r_loss_cnt != 8'hFF) begin
                            r_loss_cnt <= r_loss_cnt + 8'd1;
                        end
                    end else if (soft_rst) begin
                        r_state     <= ST_HOLD;
                        r_cnt       <= '0;
                        r_cpu_rst_n <= 1'b0;
                        r_seq_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_WAIT;
                    r_cnt       <= '0;
                    r_clk_en    <= 1'b0;
                    r_cpu_rst_n <= 1'b0;
                    r_seq_ready <= 1'b0;
                end
            endcase
        end
    end

    assign clk_en        = r_clk_en;
    assign cpu_rst_n     = r_cpu_rst_n;
    assign seq_ready     = r_seq_ready;
    assign seq_state     = r_state;
    assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_cpu_clk_rst_seq.sv
// Bench for cpu_clk_rst_seq: expected output snapshots are queued with the
// cycle they are due and compared on the falling edge of fpga_clk.
module tb_cpu_clk_rst_seq;

    logic       fpga_clk;
    logic       rst_n;
    logic       clk_lock;
    logic       soft_rst;
    logic       clk_en;
    logic       cpu_rst_n;
    logic       seq_ready;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_cnt;

    cpu_clk_rst_seq dut (
        .fpga_clk      (fpga_clk),
        .rst_n         (rst_n),
        .clk_lock      (clk_lock),
        .soft_rst      (soft_rst),
        .clk_en        (clk_en),
        .cpu_rst_n     (cpu_rst_n),
        .seq_ready     (seq_ready),
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // clock/reset block
    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    int cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    int checks_total  = 0;
    int checks_passed = 0;

    // scoreboard: {clk_en, cpu_rst_n, seq_ready, seq_state, lock_loss_cnt}
    logic [12:0] exp_q[$];
    int          at_q[$];
    string       tag_q[$];

    logic [12:0] w_obs;
    assign w_obs = {clk_en, cpu_rst_n, seq_ready, seq_state, lock_loss_cnt};

    function automatic logic [12:0] pk(logic en, logic rn, logic rdy,
                                       logic [1:0] st, logic [7:0] cnt);
        return {en, rn, rdy, st, cnt};
    endfunction

    function automatic logic [7:0] sat(int n);
        return (n > 255) ? 8'hFF : 8'(n);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            checks_passed++;
    endtask

    task automatic exp_push(input int dc, input string tag, input logic [12:0] v);
        exp_q.push_back(v);
        at_q.push_back(cyc + dc);
        tag_q.push_back(tag);
    endtask

    // Advance one cycle and compare every expectation that has come due.
    task automatic step();
        @(negedge fpga_clk);
        while (at_q.size() > 0 && at_q[0] <= cyc) begin
            check_eq(tag_q[0], {19'd0, w_obs}, {19'd0, exp_q[0]});
            void'(exp_q.pop_front());
            void'(at_q.pop_front());
            void'(tag_q.pop_front());
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (at_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (at_q.size() > 0) begin
            check_eq("timeout", at_q.size(), 0);
            exp_q.delete();
            at_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        clk_lock = 1'b0;
        soft_rst = 1'b0;
        repeat (3) step();
        check_eq("reset_outputs", {19'd0, w_obs}, 32'd0);
        rst_n = 1'b1;

        // Bring-up from a clean lock rise.
        clk_lock = 1'b1;
        exp_push(17, "bringup_pre_en", pk(0, 0, 0, 2'd0, 8'd0));
        exp_push(18, "bringup_en",     pk(1, 0, 0, 2'd1, 8'd0));
        exp_push(25, "bringup_hold",   pk(1, 0, 0, 2'd1, 8'd0));
        exp_push(26, "bringup_run",    pk(1, 1, 1, 2'd2, 8'd0));
        drain(100);

        // Lock loss in RUN.
        clk_lock = 1'b0;
        exp_push(2, "loss_still_run", pk(1, 1, 1, 2'd2, 8'd0));
        exp_push(3, "loss_wait",      pk(0, 0, 0, 2'd0, 8'd1));
        exp_push(5, "loss_stay_wait", pk(0, 0, 0, 2'd0, 8'd1));
        drain(100);

        // Glitch: 10 high, 1 low, then high again.
        clk_lock = 1'b1;
        exp_push(10, "glitch_no_en", pk(0, 0, 0, 2'd0, 8'd1));
        drain(100);
        clk_lock = 1'b0;
        step();
        clk_lock = 1'b1;
        exp_push(12, "glitch_mid",    pk(0, 0, 0, 2'd0, 8'd1));
        exp_push(17, "glitch_pre_en", pk(0, 0, 0, 2'd0, 8'd1));
        exp_push(18, "glitch_en",     pk(1, 0, 0, 2'd1, 8'd1));
        exp_push(26, "glitch_run",    pk(1, 1, 1, 2'd2, 8'd1));
        drain(100);

        // Soft reset from RUN.
        soft_rst = 1'b1;
        exp_push(1, "soft_hold",     pk(1, 0, 0, 2'd1, 8'd1));
        exp_push(8, "soft_hold_end", pk(1, 0, 0, 2'd1, 8'd1));
        exp_push(9, "soft_run",      pk(1, 1, 1, 2'd2, 8'd1));
        step();
        soft_rst = 1'b0;
        drain(100);

        // Soft reset again, plus a second pulse while in HOLD that must be ignored.
        soft_rst = 1'b1;
        exp_push(1, "soft2_hold",   pk(1, 0, 0, 2'd1, 8'd1));
        exp_push(8, "soft2_in_hold", pk(1, 0, 0, 2'd1, 8'd1));
        exp_push(9, "soft2_run",    pk(1, 1, 1, 2'd2, 8'd1));
        step();
        soft_rst = 1'b0;
        step();
        step();
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        drain(100);

        // Collision: soft_rst seen on the same edge lock_s first reads low.
        clk_lock = 1'b0;
        exp_push(3, "collide_wait", pk(0, 0, 0, 2'd0, 8'd2));
        exp_push(7, "soft_in_wait", pk(0, 0, 0, 2'd0, 8'd2));
        step();
        step();
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        step();
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        drain(100);

        // Lock lost during HOLD: back to WAIT without counting.
        clk_lock = 1'b1;
        exp_push(20, "hold_reached", pk(1, 0, 0, 2'd1, 8'd2));
        drain(100);
        clk_lock = 1'b0;
        exp_push(2, "hold_pre_loss", pk(1, 0, 0, 2'd1, 8'd2));
        exp_push(3, "hold_loss",     pk(0, 0, 0, 2'd0, 8'd2));
        drain(100);

        // Asynchronous reset in HOLD takes effect between clock edges.
        clk_lock = 1'b1;
        exp_push(20, "async_pre", pk(1, 0, 0, 2'd1, 8'd2));
        drain(100);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", {19'd0, w_obs}, 32'd0);
        clk_lock = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Repeated lock loss, counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            clk_lock = 1'b1;
            exp_push($urandom_range(18, 25), "sat_hold", pk(1, 0, 0, 2'd1, sat(i - 1)));
            exp_push(26, "sat_run", pk(1, 1, 1, 2'd2, sat(i - 1)));
            drain(100);
            clk_lock = 1'b0;
            exp_push(3, "sat_wait", pk(0, 0, 0, 2'd0, sat(i)));
            drain(100);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
